mult_div_unit: RTL and testbench

Sequential signed multiply/divide engine that responds to the multicycle control unit's `MDControl` request and feeds the HI/LO registers. The control unit pulses a start request, waits on `done`, and then asserts `WriteHI`/`WriteLO` to capture `hi_out`/`lo_out`. It also raises `div0` so the control unit can branch to its divide-by-zero exception sequence. The block sits in the datapath beside the ALU and shifter. It owns no architectural state beyond its result outputs.

---
 rtl/mult_div_unit_pkg.sv | 18 +
 rtl/mult_div_unit_if.sv | 36 +++
 rtl/mult_div_unit.sv | 183 ++++++++++++++++++
 tb/tb_mult_div_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide engine: FSM states, op codes
// and the default operand width used by the control unit and HI/LO regs.
package md_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic MD_MULT = 1'b0;
  localparam logic MD_DIV  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MULT,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } md_state_t;

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the multicycle control unit and the
// multiply/divide engine.
//
// Handshake: the master raises start for one cycle with op/a/b valid; the
// request is taken only while busy is low (engine in IDLE) and is silently
// dropped otherwise. The engine answers with a one-cycle done pulse;
// hi_out/lo_out are valid from that cycle and hold until the next result.
// A divide by zero answers with done and div0 together and leaves
// hi_out/lo_out untouched. state mirrors the engine FSM for observation.
interface mult_div_unit_if #(
  parameter int WIDTH = md_pkg::MD_WIDTH
);
  import md_pkg::*;

  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div0;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  md_state_t        state;

  modport master (
    output start, op, a, b,
    input  busy, done, div0, hi_out, lo_out, state
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div0, hi_out, lo_out, state
  );

endinterface

// File: rtl/mult_div_unit.sv
// Sequential signed multiply/divide engine feeding HI/LO.
// MULT: radix-2 Booth, one multiplier bit per cycle.
// DIV: restoring division on operand magnitudes, then one sign-fix cycle.
module mult_div_unit
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic           clk,
  input  logic           resert,
  mult_div_unit_if.slave bus
);

  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  md_state_t        state;
  logic [CW-1:0]    cnt;
  // Multiplicand for MULT, divisor magnitude for DIV.
  logic [WIDTH-1:0] mcand;
  // Booth accumulator: one guard bit so that subtracting the most negative
  // multiplicand cannot overflow.
  logic [WIDTH:0]   acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic             acc_q;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quot;
  logic             neg_q;
  logic             neg_r;
  logic             busy_r;
  logic             done_r;
  logic             div0_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   booth_hi;
  logic [WIDTH-1:0] booth_lo;
  logic             booth_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quot_nxt;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // Operand magnitudes for division; |most negative| still fits unsigned.
  always_comb begin
    a_mag = bus.a[WIDTH-1] ? (-bus.a) : bus.a;
    b_mag = bus.b[WIDTH-1] ? (-bus.b) : bus.b;
  end

  // One Booth step: add/subtract multiplicand, then arithmetic shift right.
  always_comb begin
    m_ext     = {mcand[WIDTH-1], mcand};
    booth_sum = acc_hi;
    case ({acc_lo[0], acc_q})
      2'b01:   booth_sum = acc_hi + m_ext;
      2'b10:   booth_sum = acc_hi - m_ext;
      default: booth_sum = acc_hi;
    endcase
    booth_hi = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    booth_lo = {booth_sum[0], acc_lo[WIDTH-1:1]};
    booth_q  = acc_lo[0];
  end

  // One restoring step. The partial remainder stays below the divisor
  // (at most 2^(WIDTH-1)), so the shifted value fits in WIDTH bits and
  // bit WIDTH of the trial difference is a clean borrow.
  always_comb begin
    shifted = {rem, quot[WIDTH-1]};
    trial   = shifted - {1'b0, mcand};
    if (trial[WIDTH]) begin
      rem_nxt  = shifted[WIDTH-1:0];
      quot_nxt = {quot[WIDTH-2:0], 1'b0};
    end else begin
      rem_nxt  = trial[WIDTH-1:0];
      quot_nxt = {quot[WIDTH-2:0], 1'b1};
    end
  end

  // Sign fix: quotient truncates toward zero, remainder follows dividend.
  always_comb begin
    q_fix = neg_q ? (-quot) : quot;
    r_fix = neg_r ? (-rem) : rem;
  end

  // Control FSM and datapath registers; all outputs registered.
  always_ff @(posedge clk) begin
    if (!resert) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      acc_q  <= 1'b0;
      rem    <= '0;
      quot   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      div0_r <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      done_r <= 1'b0;
      div0_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            busy_r <= 1'b1;
            cnt    <= '0;
            if (bus.op == MD_MULT) begin
              state  <= ST_MULT;
              mcand  <= bus.a;
              acc_hi <= '0;
              acc_lo <= bus.b;
              acc_q  <= 1'b0;
            end else if (bus.b == '0) begin
              state  <= ST_DONE;
              done_r <= 1'b1;
              div0_r <= 1'b1;
            end else begin
              state <= ST_DIV;
              mcand <= b_mag;
              rem   <= '0;
              quot  <= a_mag;
              neg_q <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
              neg_r <= bus.a[WIDTH-1];
            end
          end
        end
        ST_MULT: begin
          acc_hi <= booth_hi;
          acc_lo <= booth_lo;
          acc_q  <= booth_q;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            state  <= ST_DONE;
            done_r <= 1'b1;
            hi_r   <= booth_hi[WIDTH-1:0];
            lo_r   <= booth_lo;
          end
        end
        ST_DIV: begin
          rem  <= rem_nxt;
          quot <= quot_nxt;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          state  <= ST_DONE;
          done_r <= 1'b1;
          hi_r   <= r_fix;
          lo_r   <= q_fix;
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          busy_r <= 1'b0;
          cnt    <= '0;
        end
        default: begin
          state  <= ST_IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.div0   = div0_r;
  assign bus.hi_out = hi_r;
  assign bus.lo_out = lo_r;
  assign bus.state  = state;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed plus randomized bench for mult_div_unit; expected results come
// from plain 64-bit signed arithmetic.
module tb_mult_div_unit;
  import md_pkg::*;

  logic clk;
  logic resert;

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .resert(resert),
    .bus   (bus)
  );

  int          n_cmp;
  int          n_err;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;
  logic [63:0] exp_q[$];

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'h8000_0000;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'h0000_0000;
      3:       v = 32'h0000_0001;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Drive one request and check timing, result and post-DONE behaviour.
  // Latency is counted as the cycle index after the start edge k
  // (the cycle right after edge k is k+1).
  task automatic run_op(input logic opv, input logic [31:0] av, input logic [31:0] bv,
                        input bit repulse, input string tag);
    logic [31:0] eh;
    logic [31:0] el;
    logic        ed0;
    int          elat;
    int          lat;
    logic [63:0] pair;
    longint      sa;
    longint      sb;
    longint      res;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    if (opv == MD_MULT) begin
      res  = sa * sb;
      eh   = res[63:32];
      el   = res[31:0];
      ed0  = 1'b0;
      elat = 33;
    end else if (bv == 32'd0) begin
      eh   = exp_hi;
      el   = exp_lo;
      ed0  = 1'b1;
      elat = 1;
    end else begin
      res  = sa / sb;
      el   = res[31:0];
      res  = sa % sb;
      eh   = res[31:0];
      ed0  = 1'b0;
      elat = 34;
    end
    exp_q.push_back({eh, el});

    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = opv;
    bus.a     = av;
    bus.b     = bv;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = 1'($urandom);
    bus.a     = $urandom;
    bus.b     = $urandom;
    check($sformatf("%s_busy_start", tag), 64'(bus.busy), 64'(1));
    lat = 1;
    while (bus.done !== 1'b1 && lat < 60) begin
      if (repulse && lat == 10) bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.a     = $urandom;
      bus.b     = $urandom;
      lat++;
    end
    pair = exp_q.pop_front();
    check($sformatf("%s_latency", tag), 64'(lat), 64'(elat));
    check($sformatf("%s_hi", tag), 64'(bus.hi_out), 64'(pair[63:32]));
    check($sformatf("%s_lo", tag), 64'(bus.lo_out), 64'(pair[31:0]));
    check($sformatf("%s_div0", tag), 64'(bus.div0), 64'(ed0));
    check($sformatf("%s_busy_done", tag), 64'(bus.busy), 64'(1));
    exp_hi = pair[63:32];
    exp_lo = pair[31:0];

    @(posedge clk);
    #1;
    check($sformatf("%s_done_pulse", tag), 64'(bus.done), 64'(0));
    check($sformatf("%s_div0_pulse", tag), 64'(bus.div0), 64'(0));
    check($sformatf("%s_busy_end", tag), 64'(bus.busy), 64'(0));
    check($sformatf("%s_hi_hold", tag), 64'(bus.hi_out), 64'(exp_hi));
    check($sformatf("%s_lo_hold", tag), 64'(bus.lo_out), 64'(exp_lo));
  endtask

  // directed sequence, then random operations, then report
  initial begin
    int          done_seen;
    logic        opv;
    logic [31:0] av;
    logic [31:0] bv;
    n_cmp     = 0;
    n_err     = 0;
    exp_hi    = 32'd0;
    exp_lo    = 32'd0;
    resert    = 1'b0;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_div0", 64'(bus.div0), 64'(0));
    check("rst_hi", 64'(bus.hi_out), 64'(0));
    check("rst_lo", 64'(bus.lo_out), 64'(0));
    check("rst_state", 64'(bus.state), 64'(ST_IDLE));
    resert = 1'b1;

    run_op(MD_MULT, 32'd7, 32'hFFFF_FFFD, 1'b0, "mult_7_m3");
    check("mult_7_m3_hi_const", 64'(bus.hi_out), 64'h0000_0000_FFFF_FFFF);
    check("mult_7_m3_lo_const", 64'(bus.lo_out), 64'h0000_0000_FFFF_FFEB);
    run_op(MD_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, "mult_min_min");
    check("mult_min_min_hi_const", 64'(bus.hi_out), 64'h0000_0000_4000_0000);
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_m7_2");
    check("div_m7_2_lo_const", 64'(bus.lo_out), 64'h0000_0000_FFFF_FFFD);
    check("div_m7_2_hi_const", 64'(bus.hi_out), 64'h0000_0000_FFFF_FFFF);
    run_op(MD_DIV, 32'd5, 32'd0, 1'b0, "div_by_zero");
    run_op(MD_MULT, 32'h0001_2345, 32'hFFFF_0F0F, 1'b1, "mult_repulse");

    // DIV aborted by reset at edge k+15
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = MD_DIV;
    bus.a     = 32'h1234_5678;
    bus.b     = 32'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    resert = 1'b0;
    @(posedge clk);
    #1;
    resert = 1'b1;
    check("abort_busy", 64'(bus.busy), 64'(0));
    check("abort_done", 64'(bus.done), 64'(0));
    check("abort_div0", 64'(bus.div0), 64'(0));
    check("abort_hi", 64'(bus.hi_out), 64'(0));
    check("abort_lo", 64'(bus.lo_out), 64'(0));
    check("abort_state", 64'(bus.state), 64'(ST_IDLE));
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) done_seen++;
    end
    check("abort_no_done", 64'(done_seen), 64'(0));

    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_overflow");
    check("div_overflow_lo_const", 64'(bus.lo_out), 64'h0000_0000_8000_0000);
    check("div_overflow_hi_const", 64'(bus.hi_out), 64'h0000_0000_0000_0000);

    for (int i = 0; i < 24; i++) begin
      opv = 1'($urandom_range(0, 1));
      av  = pick_operand();
      bv  = pick_operand();
      run_op(opv, av, bv, 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
